spram_arb: RTL and testbench
============================

# spram_arb

Two-requester arbiter that shares one synchronous single-port RAM (`spram`) between port A (CPU) and port B (DMA/host loader). Each cycle it grants at most one access, using round-robin on contention, and drives the RAM's addr/din/we/re. It also routes the one-cycle-late read data back to the port that issued the read. It sits directly in front of `spram`, and both masters see a simple req/ack interface.

## Interface
- `ADDR_WIDTH`, default 10: RAM address width; must match the attached `spram`.
- `DATA_WIDTH`, default 16: RAM data width.

- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a_req`  in  1  port A access request; held with a_we/a_addr/a_din stable until a_ack.
- `a_we`  in  1  1 = write, 0 = read.
- `a_addr`  in  ADDR_WIDTH  port A address.
- `a_din`  in  DATA_WIDTH  port A write data.
- `a_ack`  out  1  access accepted this cycle (combinational from requests and pointer).
- `a_rdata`  out  DATA_WIDTH  read data; meaningful only while a_rvalid.
- `a_rvalid`  out  1  registered; high for one cycle, the cycle after a read ack.
- `b_req`, `b_we`, `b_addr`, `b_din`, `b_ack`, `b_rdata`, `b_rvalid`: identical to the port A signals, for port B.
- `ram_addr`  out  ADDR_WIDTH  to spram addr.
- `ram_din`  out  DATA_WIDTH  to spram din.
- `ram_we`  out  1  to spram we.
- `ram_re`  out  1  to spram re.
- `ram_dout`  in  DATA_WIDTH  from spram dout.

## Operation
- **State:** `last` (1 bit, last port granted), `rd_pend` (1 bit), `rd_owner` (1 bit).
- **Grant, combinational each cycle:**
  - only a_req: grant A.
  - only b_req: grant B.
  - both: grant the port ≠ `last`.
  - neither: no grant.
- **Ack:** the granted port's ack = 1 and the other ack = 0. At most one ack per cycle.
- **RAM drive on grant:**
  - ram_addr and ram_din come from the granted port.
  - ram_we = granted we.
  - ram_re = ~granted we.
- **RAM drive with no grant:** ram_we = ram_re = 0, ram_addr = 0, ram_din = 0.
- **`last` update:** set to the granted port on every grant; holds when idle.
- **Read tracking:** on a read grant, next edge sets rd_pend = 1 and rd_owner = granted port. Otherwise rd_pend = 0.
- **Read return:**
  - a_rvalid = rd_pend & (rd_owner==A).
  - b_rvalid = rd_pend & (rd_owner==B).
  - a_rdata = b_rdata = ram_dout (unmasked pass-through).
- **Writes:** no return strobe; the write is complete at the edge where ack is high.
- **Throughput:** one access per cycle, back-to-back, with any mix of ports and read/write.
- **Fairness:** under continuous contention, grants alternate A, B, A, B…; neither port waits more than 1 cycle.

## Timing
- **Reset values (async, immediate on rst_n low):**
  - last = B, so A wins the first contention.
  - rd_pend = 0, rd_owner = A.
  - a_rvalid = b_rvalid = 0.
  - Acks and ram_* follow the combinational rules, so they are 0 if no req.
- **Read latency:** ack at cycle N → rvalid and data at cycle N+1.
- **Read-after-write:** a write acked at N followed by a read of the same address acked at N+1 returns the new data at N+2.
- **Consecutive reads:** a read acked at N+1 produces rvalid at N+2 even if the port's previous rvalid was at N+1, so a port can see rvalid on consecutive cycles.
- **Reset mid-read:**
  - A pending rvalid is dropped; the requester must reissue.
  - The RAM write enable is combinationally 0 while no req, so no spurious write is issued.
- **Handshake rules:**
  - req may drop only after ack.
  - Dropping req early is a protocol violation; the arbiter simply stops granting.
  - No combinational path from ack to req is permitted in masters.

## Test plan
- **Reset:** hold rst_n=0 with a_req=b_req=1 → a_rvalid=b_rvalid=0. After release, first cycle grants A (a_ack=1, b_ack=0).
- **Single write/read:** A writes 0x1234 to addr 0x005 (ack same cycle), then reads 0x005 → a_rvalid next cycle with a_rdata=0x1234; b_rvalid stays 0.
- **Contention:**
  - Both request continuously for 6 cycles → acks A,B,A,B,A,B.
  - Then b_req only → B granted every cycle.
- **Back-to-back reads across ports:** A reads 0x010 (=0xAAAA) at N, B reads 0x011 (=0x5555) at N+1 → a_rvalid/0xAAAA at N+1, b_rvalid/0x5555 at N+2, never both valid together.
- **Reset mid-read:** A read acked at N, rst_n pulsed low before edge N+1 → a_rvalid stays 0 and last returns to B.
- **Write/read ordering:** B writes 0x0F0F to 0x3FF at N, A reads 0x3FF at N+1 → a_rdata=0x0F0F at N+2 (top-address wrap boundary).

Source files
------------

// File: rtl/spram_arb.sv
// Round-robin arbiter sharing one synchronous single-port RAM between two masters.
// Read data returns one cycle after the grant, tagged to the port that issued it.
module spram_arb #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_din,
    output logic                  a_ack,
    output logic [DATA_WIDTH-1:0] a_rdata,
    output logic                  a_rvalid,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_din,
    output logic                  b_ack,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  b_rvalid,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_we,
    output logic                  ram_re,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    logic last;
    logic rd_pend;
    logic rd_owner;
    logic gnt_a;
    logic gnt_b;
    logic rd_gnt;

    // On contention the port that was not served last wins
    always_comb begin
        gnt_a = a_req & (~b_req | (last == PORT_B));
        gnt_b = b_req & (~a_req | (last == PORT_A));
    end

    always_comb begin
        ram_addr = '0;
        ram_din  = '0;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        rd_gnt   = 1'b0;
        if (gnt_a) begin
            ram_addr = a_addr;
            ram_din  = a_din;
            ram_we   = a_we;
            ram_re   = ~a_we;
            rd_gnt   = ~a_we;
        end else if (gnt_b) begin
            ram_addr = b_addr;
            ram_din  = b_din;
            ram_we   = b_we;
            ram_re   = ~b_we;
            rd_gnt   = ~b_we;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last     <= PORT_B;
            rd_pend  <= 1'b0;
            rd_owner <= PORT_A;
        end else begin
            if (gnt_a || gnt_b) begin
                last <= gnt_b ? PORT_B : PORT_A;
            end
            rd_pend <= rd_gnt;
            if (rd_gnt) begin
                rd_owner <= gnt_b ? PORT_B : PORT_A;
            end
        end
    end

    assign a_ack    = gnt_a;
    assign b_ack    = gnt_b;
    assign a_rvalid = rd_pend & (rd_owner == PORT_A);
    assign b_rvalid = rd_pend & (rd_owner == PORT_B);
    assign a_rdata  = ram_dout;
    assign b_rdata  = ram_dout;

endmodule

// File: tb/tb_spram_arb.sv
// Directed-vector bench for spram_arb with a behavioural synchronous RAM behind it.
module tb_spram_arb;

    localparam int AW = 10;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr, ram_addr;
    logic [DW-1:0] a_din, b_din, ram_din, ram_dout;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          a_ack, b_ack, a_rvalid, b_rvalid, ram_we, ram_re;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spram_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
        .a_ack(a_ack), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
        .b_ack(b_ack), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .ram_re(ram_re), .ram_dout(ram_dout)
    );

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        if (ram_re) ram_dout <= mem[ram_addr];
    end

    typedef struct {
        logic          ar, aw;
        logic [AW-1:0] aa;
        logic [DW-1:0] ad;
        logic          br, bw;
        logic [AW-1:0] ba;
        logic [DW-1:0] bd;
        logic          ea_ack, eb_ack, ea_rv, eb_rv, chk_data;
        logic [DW-1:0] edata;
        logic          ewe, ere;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] edin;
    } vec_t;

    vec_t vt [19];

    function automatic vec_t mk(
        logic ar, logic aw, logic [AW-1:0] aa, logic [DW-1:0] ad,
        logic br, logic bw, logic [AW-1:0] ba, logic [DW-1:0] bd,
        logic ea_ack, logic eb_ack, logic ea_rv, logic eb_rv,
        logic chk_data, logic [DW-1:0] edata,
        logic ewe, logic ere, logic [AW-1:0] eaddr, logic [DW-1:0] edin);
        vec_t v;
        v.ar = ar; v.aw = aw; v.aa = aa; v.ad = ad;
        v.br = br; v.bw = bw; v.ba = ba; v.bd = bd;
        v.ea_ack = ea_ack; v.eb_ack = eb_ack;
        v.ea_rv = ea_rv; v.eb_rv = eb_rv;
        v.chk_data = chk_data; v.edata = edata;
        v.ewe = ewe; v.ere = ere; v.eaddr = eaddr; v.edin = edin;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(vec_t v);
        a_req = v.ar; a_we = v.aw; a_addr = v.aa; a_din = v.ad;
        b_req = v.br; b_we = v.bw; b_addr = v.ba; b_din = v.bd;
    endtask

    initial begin
        //            A req/we/addr/din        B req/we/addr/din       aak bak arv brv chk data      we re addr   din
        vt[0]  = mk(1,1,'h005,'h1234, 1,1,'h011,'h5555, 1,0,0,0, 0,'h0000, 1,0,'h005,'h1234);
        vt[1]  = mk(1,0,'h005,'h0000, 1,1,'h011,'h5555, 0,1,0,0, 0,'h0000, 1,0,'h011,'h5555);
        vt[2]  = mk(1,0,'h005,'h0000, 0,0,'h000,'h0000, 1,0,0,0, 0,'h0000, 0,1,'h005,'h0000);
        vt[3]  = mk(0,0,'h000,'h0000, 0,0,'h000,'h0000, 0,0,1,0, 1,'h1234, 0,0,'h000,'h0000);
        vt[4]  = mk(1,1,'h010,'hAAAA, 0,0,'h000,'h0000, 1,0,0,0, 0,'h0000, 1,0,'h010,'hAAAA);
        vt[5]  = mk(0,0,'h000,'h0000, 1,1,'h3FF,'h0F0F, 0,1,0,0, 0,'h0000, 1,0,'h3FF,'h0F0F);
        vt[6]  = mk(1,0,'h3FF,'h0000, 0,0,'h000,'h0000, 1,0,0,0, 0,'h0000, 0,1,'h3FF,'h0000);
        vt[7]  = mk(0,0,'h000,'h0000, 0,0,'h000,'h0000, 0,0,1,0, 1,'h0F0F, 0,0,'h000,'h0000);
        vt[8]  = mk(0,0,'h000,'h0000, 1,0,'h011,'h0000, 0,1,0,0, 0,'h0000, 0,1,'h011,'h0000);
        vt[9]  = mk(1,0,'h010,'h0000, 1,0,'h011,'h0000, 1,0,0,1, 1,'h5555, 0,1,'h010,'h0000);
        vt[10] = mk(1,0,'h010,'h0000, 1,0,'h011,'h0000, 0,1,1,0, 1,'hAAAA, 0,1,'h011,'h0000);
        vt[11] = mk(1,0,'h010,'h0000, 1,0,'h011,'h0000, 1,0,0,1, 1,'h5555, 0,1,'h010,'h0000);
        vt[12] = mk(1,0,'h010,'h0000, 1,0,'h011,'h0000, 0,1,1,0, 1,'hAAAA, 0,1,'h011,'h0000);
        vt[13] = mk(1,0,'h010,'h0000, 1,0,'h011,'h0000, 1,0,0,1, 1,'h5555, 0,1,'h010,'h0000);
        vt[14] = mk(1,0,'h010,'h0000, 1,0,'h011,'h0000, 0,1,1,0, 1,'hAAAA, 0,1,'h011,'h0000);
        vt[15] = mk(0,0,'h000,'h0000, 1,0,'h011,'h0000, 0,1,0,1, 1,'h5555, 0,1,'h011,'h0000);
        vt[16] = mk(0,0,'h000,'h0000, 1,1,'h020,'h7777, 0,1,0,1, 1,'h5555, 1,0,'h020,'h7777);
        vt[17] = mk(0,0,'h000,'h0000, 1,0,'h020,'h0000, 0,1,0,0, 0,'h0000, 0,1,'h020,'h0000);
        vt[18] = mk(0,0,'h000,'h0000, 0,0,'h000,'h0000, 0,0,0,1, 1,'h7777, 0,0,'h000,'h0000);

        // Reset held with both masters requesting
        rst_n = 1'b0;
        drive(vt[0]);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_a_rvalid", a_rvalid, 0);
        chk("rst_b_rvalid", b_rvalid, 0);
        chk("rst_a_ack", a_ack, 1);
        chk("rst_b_ack", b_ack, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            if (i != 0) @(negedge clk);
            drive(vt[i]);
            #1;
            chk($sformatf("v%0d_a_ack", i), a_ack, vt[i].ea_ack);
            chk($sformatf("v%0d_b_ack", i), b_ack, vt[i].eb_ack);
            chk($sformatf("v%0d_a_rvalid", i), a_rvalid, vt[i].ea_rv);
            chk($sformatf("v%0d_b_rvalid", i), b_rvalid, vt[i].eb_rv);
            chk($sformatf("v%0d_ram_we", i), ram_we, vt[i].ewe);
            chk($sformatf("v%0d_ram_re", i), ram_re, vt[i].ere);
            chk($sformatf("v%0d_ram_addr", i), ram_addr, vt[i].eaddr);
            chk($sformatf("v%0d_ram_din", i), ram_din, vt[i].edin);
            if (vt[i].chk_data) begin
                chk($sformatf("v%0d_a_rdata", i), a_rdata, vt[i].edata);
                chk($sformatf("v%0d_b_rdata", i), b_rdata, vt[i].edata);
            end
            if (a_rvalid && b_rvalid) begin
                chk($sformatf("v%0d_both_rvalid", i), 1, 0);
            end
        end

        // Reset pulsed between a read grant and its return edge
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_addr = 'h005; a_din = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_din = '0;
        #1;
        chk("mid_a_ack", a_ack, 1);
        #2;
        rst_n = 1'b0;
        a_req = 1'b0;
        #1;
        chk("mid_ram_we", ram_we, 0);
        chk("mid_ram_re", ram_re, 0);
        @(posedge clk);
        #1;
        chk("mid_a_rvalid_in_rst", a_rvalid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        a_req = 1'b1; a_we = 1'b1; a_addr = 'h030; a_din = 'h1111;
        b_req = 1'b1; b_we = 1'b1; b_addr = 'h031; b_din = 'h2222;
        #1;
        chk("post_rst_a_rvalid", a_rvalid, 0);
        chk("post_rst_a_ack", a_ack, 1);
        chk("post_rst_b_ack", b_ack, 0);
        @(negedge clk);
        a_req = 1'b0;
        #1;
        chk("post_rst2_b_ack", b_ack, 1);
        @(negedge clk);
        b_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
